fpu_int_store_unit: RTL and testbench
=====================================

Name: fpu_int_store_unit

Overview:
Stage directly downstream of the FP80-to-int32 converter in the 8087 FIST/FISTP path. Takes the converted integer and its exception flags and applies the control-word masks. On a masked invalid or overflow it substitutes the integer-indefinite value. It narrows to int16 when required, then serialises the result as 16-bit little-endian word writes over a req/ack memory handshake, with an ack timeout.

Parameters:
ADDR_WIDTH, 20, width of the word-write byte address (8086 physical address space)
ACK_TIMEOUT, 255, max cycles the unit waits for mem_ack per word before a bus error; legal range 1..65535

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
int_in  in  32  signed integer from the converter (int_out)
int_size  in  1  0 = store int16 (1 word), 1 = store int32 (2 words)
in_invalid  in  1  converter flag_invalid
in_overflow  in  1  converter flag_overflow
in_inexact  in  1  converter flag_inexact
im_mask  in  1  control-word IM (1 = invalid masked)
pm_mask  in  1  control-word PM (1 = precision masked)
base_addr  in  ADDR_WIDTH  byte address of the low word
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  16  write data
mem_wr_req  out  1  write request
mem_ack  in  1  write accepted
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
exc_invalid  out  1  IE to status word; valid with done
exc_precision  out  1  PE to status word; valid with done
fault  out  1  unmasked exception (no store performed); valid with done
bus_error  out  1  ack timeout; valid with done

Behaviour:
- Reset (async on reset_n low): state IDLE. All outputs 0, including mem_addr and mem_wdata. Counters cleared. Reset mid-transfer abandons it immediately; no done pulse.
- FSM states: IDLE, CHECK, WRITE, GAP, FIN.
- IDLE:
  - start=1 latches int_in, int_size, the three flags, both masks and base_addr, then moves to CHECK.
  - busy=1 from the next cycle.
- CHECK (1 cycle):
  - Invalid condition inv = in_invalid | in_overflow | (int_size==0 & int_in outside -32768..32767).
  - inv & !im_mask: fault=1, no writes, go to FIN.
  - inv & im_mask: store data becomes integer indefinite, 0x8000 (int16) or 0x80000000 (int32).
  - Otherwise store data is int_in, or int_in[15:0] for int16.
  - exc_invalid = inv. exc_precision = in_inexact & !inv.
  - PE never blocks the store, regardless of pm_mask; pm_mask only gates fault (PE with pm_mask=0 sets fault but the store still completes).
  - Words to write: 1 for int16, 2 for int32. Go to WRITE.
- WRITE:
  - mem_wr_req=1; mem_addr and mem_wdata held stable until ack.
  - Word 0 = low 16 bits at base_addr. Word 1 = high 16 bits at base_addr+2, computed modulo 2^ADDR_WIDTH (wraps).
  - When mem_ack=1 is sampled: req deasserts the next cycle. Go to GAP if words remain, else FIN.
  - The timeout counter increments each cycle without ack. If it reaches ACK_TIMEOUT: bus_error=1, req drops, go to FIN. Remaining words are not written.
  - mem_ack while req=0 is ignored.
- GAP (1 cycle): req=0. Advance word index, reload timeout counter, return to WRITE.
- FIN (1 cycle): done=1 and busy=0, then IDLE.
  - exc_*/fault/bus_error hold their values until the next accepted start, which clears them.
- start while busy is ignored (not queued).
- Latency with zero-wait ack (ack the same cycle req rises): int16 = start + 4 cycles to done; int32 = start + 6 cycles.

Decomposition:
- Shared package fpu_pkg holds:
  - INT16_INDEFINITE = 16'h8000
  - INT32_INDEFINITE = 32'h80000000
  - int-size encoding constants
  - FSM state enum
- One natural sub-module: fpu_int_range_check. Combinational; takes int_in, int_size and flags; outputs inv and the selected store data.

Test Plan:
- int32 0x12345678, base 0x01000, no flags, ack same cycle -> writes 0x5678@0x01000 then 0x1234@0x01002; done at cycle 6; all exc 0.
- int16 40000 (0x00009C40), im_mask=1 -> single write 0x8000@base; exc_invalid=1, fault=0.
- int32 with in_overflow=1, im_mask=0 -> no mem_wr_req ever; done with fault=1, exc_invalid=1.
- int32 -2 (0xFFFFFFFE), ack delayed 3 cycles per word, in_inexact=1, pm_mask=1 -> req/addr/data stable through wait; writes 0xFFFE, 0xFFFF; exc_precision=1, fault=0.
- base 0xFFFFE, int32 -> second write at 0x00000; ACK_TIMEOUT=4 with ack never asserted -> bus_error=1 after 4 wait cycles, only word 0 attempted.
- reset_n low during WRITE -> outputs 0 immediately, no done; next start behaves normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants and FSM state type for the FIST/FISTP store path
// Contents: integer-indefinite values, int-size encoding, store-unit FSM states.
package fpu_pkg;

  localparam logic [15:0] INT16_INDEFINITE = 16'h8000;
  localparam logic [31:0] INT32_INDEFINITE = 32'h8000_0000;

  // int_size encoding
  localparam logic INT_SIZE_16 = 1'b0;
  localparam logic INT_SIZE_32 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WRITE = 3'd2,
    ST_GAP   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/fpu_int_range_check.sv
// rtl/fpu_int_range_check.sv - invalid detection and store-data selection for integer stores
// Ports:
//   int_in      in  32  converted signed integer
//   int_size    in  1   INT_SIZE_16 / INT_SIZE_32
//   in_invalid  in  1   converter invalid flag
//   in_overflow in  1   converter overflow flag
//   inv         out 1   invalid condition (flags or int16 range miss)
//   store_data  out 32  value to store; indefinite when inv (upper half 0 for int16)
module fpu_int_range_check
  import fpu_pkg::*;
(
  input  logic [31:0] int_in,
  input  logic        int_size,
  input  logic        in_invalid,
  input  logic        in_overflow,
  output logic        inv,
  output logic [31:0] store_data
);

  logic out_of_16;

  always_comb begin
    // An int32 fits int16 only when bits 31..15 are a pure sign extension.
    out_of_16 = !((int_in[31:15] == 17'h0_0000) || (int_in[31:15] == 17'h1_FFFF));
    inv       = in_invalid | in_overflow | ((int_size == INT_SIZE_16) & out_of_16);
    if (int_size == INT_SIZE_32) begin
      store_data = inv ? INT32_INDEFINITE : int_in;
    end else begin
      store_data = {16'h0000, (inv ? INT16_INDEFINITE : int_in[15:0])};
    end
  end

endmodule

// File: rtl/fpu_int_store_unit.sv
// rtl/fpu_int_store_unit.sv - applies CW masks to a converted integer and writes it as 16-bit words
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   start                           one-cycle request, sampled in IDLE
//   int_in, int_size                converted integer, 0=int16 / 1=int32
//   in_invalid/overflow/inexact     converter flags
//   im_mask, pm_mask                control-word IM / PM
//   base_addr                       byte address of low word
//   mem_addr, mem_wdata, mem_wr_req word-write request; mem_ack accepts it
//   busy, done                      activity / one-cycle completion pulse
//   exc_invalid, exc_precision      status-word IE / PE, valid with done
//   fault, bus_error                unmasked exception / ack timeout, valid with done
module fpu_int_store_unit
  import fpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           int_in,
  input  logic                  int_size,
  input  logic                  in_invalid,
  input  logic                  in_overflow,
  input  logic                  in_inexact,
  input  logic                  im_mask,
  input  logic                  pm_mask,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_wr_req,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  exc_invalid,
  output logic                  exc_precision,
  output logic                  fault,
  output logic                  bus_error
);

  // The timeout fires on the wait cycle in which the count would reach ACK_TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_e state_q, state_d;

  logic [31:0]           int_q;
  logic                  size_q;
  logic                  invalid_q;
  logic                  overflow_q;
  logic                  inexact_q;
  logic                  im_q;
  logic                  pm_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [15:0]           hi_q;
  logic                  word_idx_q;
  logic [15:0]           cnt_q;
  logic                  exc_inv_q;
  logic                  exc_pe_q;
  logic                  fault_q;
  logic                  berr_q;

  logic                  inv;
  logic [31:0]           store_data;

  fpu_int_range_check u_range_check (
    .int_in      (int_q),
    .int_size    (size_q),
    .in_invalid  (invalid_q),
    .in_overflow (overflow_q),
    .inv         (inv),
    .store_data  (store_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: state_d = (inv && !im_q) ? ST_FIN : ST_WRITE;
      ST_WRITE: begin
        if (mem_ack) begin
          state_d = ((size_q == INT_SIZE_32) && !word_idx_q) ? ST_GAP : ST_FIN;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_FIN;
        end
      end
      ST_GAP:   state_d = ST_WRITE;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_wr_req    = (state_q == ST_WRITE);
    busy          = (state_q == ST_CHECK) || (state_q == ST_WRITE) || (state_q == ST_GAP);
    done          = (state_q == ST_FIN);
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    exc_invalid   = exc_inv_q;
    exc_precision = exc_pe_q;
    fault         = fault_q;
    bus_error     = berr_q;
  end

  // Operand capture, word sequencing and sticky result flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_q      <= '0;
      size_q     <= 1'b0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
      inexact_q  <= 1'b0;
      im_q       <= 1'b0;
      pm_q       <= 1'b0;
      base_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hi_q       <= '0;
      word_idx_q <= 1'b0;
      cnt_q      <= '0;
      exc_inv_q  <= 1'b0;
      exc_pe_q   <= 1'b0;
      fault_q    <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            int_q      <= int_in;
            size_q     <= int_size;
            invalid_q  <= in_invalid;
            overflow_q <= in_overflow;
            inexact_q  <= in_inexact;
            im_q       <= im_mask;
            pm_q       <= pm_mask;
            base_q     <= base_addr;
            exc_inv_q  <= 1'b0;
            exc_pe_q   <= 1'b0;
            fault_q    <= 1'b0;
            berr_q     <= 1'b0;
          end
        end
        ST_CHECK: begin
          exc_inv_q  <= inv;
          exc_pe_q   <= inexact_q & !inv;
          // Unmasked PE flags a fault but the store still goes ahead.
          fault_q    <= (inv & !im_q) | (inexact_q & !inv & !pm_q);
          addr_q     <= base_q;
          wdata_q    <= store_data[15:0];
          hi_q       <= store_data[31:16];
          word_idx_q <= 1'b0;
          cnt_q      <= '0;
        end
        ST_WRITE: begin
          if (!mem_ack) begin
            if (cnt_q == TMO_LAST) begin
              berr_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        ST_GAP: begin
          word_idx_q <= 1'b1;
          addr_q     <= addr_q + ADDR_WIDTH'(2);
          wdata_q    <= hi_q;
          cnt_q      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_int_store_unit.sv
// tb/tb_fpu_int_store_unit.sv - directed scoreboard bench for fpu_int_store_unit
module tb_fpu_int_store_unit;

  localparam int AW = 20;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   int_in = '0;
  logic          int_size = 1'b0;
  logic          in_invalid = 1'b0;
  logic          in_overflow = 1'b0;
  logic          in_inexact = 1'b0;
  logic          im_mask = 1'b0;
  logic          pm_mask = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_wr_req;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          done;
  logic          exc_invalid;
  logic          exc_precision;
  logic          fault;
  logic          bus_error;

  fpu_int_store_unit #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .int_in        (int_in),
    .int_size      (int_size),
    .in_invalid    (in_invalid),
    .in_overflow   (in_overflow),
    .in_inexact    (in_inexact),
    .im_mask       (im_mask),
    .pm_mask       (pm_mask),
    .base_addr     (base_addr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wr_req    (mem_wr_req),
    .mem_ack       (mem_ack),
    .busy          (busy),
    .done          (done),
    .exc_invalid   (exc_invalid),
    .exc_precision (exc_precision),
    .fault         (fault),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected word writes, {addr, data}, pushed when an operation is issued.
  logic [35:0] exp_q[$];
  logic [35:0] exp_e;

  int          ack_delay = 0;  // wait cycles before ack; -1 = never ack
  int          wait_cnt = 0;
  int          req_cycles = 0;
  bit          in_req = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [15:0]   hold_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // Memory responder: pops the scoreboard when a request appears, checks
  // stability while it waits, and acks after ack_delay wait cycles.
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ack  = 1'b0;
      in_req   = 1'b0;
      wait_cnt = 0;
    end else if (mem_wr_req) begin
      req_cycles++;
      if (!in_req) begin
        in_req    = 1'b1;
        wait_cnt  = 0;
        hold_addr = mem_addr;
        hold_data = mem_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(exp_e[35:16]));
          check("wr_data", 32'(mem_wdata), 32'(exp_e[15:0]));
        end
      end else begin
        check("addr_stable", 32'(mem_addr), 32'(hold_addr));
        check("data_stable", 32'(mem_wdata), 32'(hold_data));
      end
      mem_ack = (ack_delay >= 0) && (wait_cnt == ack_delay);
      wait_cnt++;
    end else begin
      mem_ack = 1'b0;
      in_req  = 1'b0;
    end
  end

  // fl = {in_invalid, in_overflow, in_inexact, im_mask, pm_mask}
  // ex = {exc_invalid, exc_precision, fault, bus_error}
  // exp_cyc counts the start cycle as cycle 1; 0 skips the latency check.
  task automatic do_op(input string tag, input logic [31:0] val, input logic sz,
                       input logic [4:0] fl, input logic [AW-1:0] base,
                       input int exp_cyc, input logic [3:0] ex, input bit glitch);
    int lat;
    bit got;
    int_in    = val;
    int_size  = sz;
    {in_invalid, in_overflow, in_inexact, im_mask, pm_mask} = fl;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    int_in    = ~val;
    base_addr = ~base;
    {in_invalid, in_overflow, in_inexact, im_mask, pm_mask} = ~fl;
    check({tag, ":busy"}, 32'(busy), 32'd1);
    lat = 1;
    got = 1'b0;
    while (lat < 200 && !got) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (glitch && lat == 2) begin
          start    = 1'b1;
          int_size = 1'b0;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    check({tag, ":done_seen"}, 32'(got), 32'd1);
    if (got) begin
      if (exp_cyc > 0) check({tag, ":latency"}, 32'(lat + 1), 32'(exp_cyc));
      check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
      check({tag, ":flags"}, 32'({exc_invalid, exc_precision, fault, bus_error}), 32'(ex));
      check({tag, ":words_left"}, 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      check({tag, ":done_pulse"}, 32'(done), 32'd0);
      check({tag, ":flags_held"}, 32'({exc_invalid, exc_precision, fault, bus_error}), 32'(ex));
      check({tag, ":idle_req"}, 32'(mem_wr_req), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst:req", 32'(mem_wr_req), 32'd0);
    check("rst:busy_done", 32'({busy, done}), 32'd0);
    check("rst:addr", 32'(mem_addr), 32'd0);
    check("rst:wdata", 32'(mem_wdata), 32'd0);
    check("rst:flags", 32'({exc_invalid, exc_precision, fault, bus_error}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // int32 zero-wait, two words
    ack_delay = 0;
    push_wr(20'h01000, 16'h5678);
    push_wr(20'h01002, 16'h1234);
    do_op("i32_basic", 32'h1234_5678, 1'b1, 5'b00011, 20'h01000, 6, 4'b0000, 1'b0);

    // int16 out of range, masked -> indefinite; PE suppressed by IE
    push_wr(20'h02000, 16'h8000);
    do_op("i16_ovr_masked", 32'h0000_9C40, 1'b0, 5'b00110, 20'h02000, 4, 4'b1000, 1'b0);

    // int32 overflow unmasked -> fault, no writes
    do_op("i32_ovf_fault", 32'h7FFF_FFFF, 1'b1, 5'b01000, 20'h02100, 0, 4'b1010, 1'b0);

    // int32 -2, 3 wait cycles per word, PE masked, ignored start mid-operation
    ack_delay = 3;
    push_wr(20'h03000, 16'hFFFE);
    push_wr(20'h03002, 16'hFFFF);
    do_op("i32_wait", 32'hFFFF_FFFE, 1'b1, 5'b00111, 20'h03000, 12, 4'b0100, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_restart", 32'({busy, mem_wr_req}), 32'd0);
    end

    // int16 -5 with PE unmasked: fault but store completes
    ack_delay = 0;
    push_wr(20'h04000, 16'hFFFB);
    do_op("i16_pe_unmasked", 32'hFFFF_FFFB, 1'b0, 5'b00100, 20'h04000, 4, 4'b0110, 1'b0);

    // int16 boundaries
    push_wr(20'h04010, 16'h8000);
    do_op("i16_min", 32'hFFFF_8000, 1'b0, 5'b00000, 20'h04010, 4, 4'b0000, 1'b0);
    push_wr(20'h04020, 16'h7FFF);
    do_op("i16_max", 32'h0000_7FFF, 1'b0, 5'b00000, 20'h04020, 4, 4'b0000, 1'b0);
    do_op("i16_max_plus1", 32'h0000_8000, 1'b0, 5'b00000, 20'h04030, 0, 4'b1010, 1'b0);

    // Masked invalid on int32 -> 0x80000000
    push_wr(20'h04040, 16'h0000);
    push_wr(20'h04042, 16'h8000);
    do_op("i32_inv_masked", 32'h0000_0001, 1'b1, 5'b10010, 20'h04040, 6, 4'b1000, 1'b0);

    // Address wrap on second word
    push_wr(20'hFFFFE, 16'hBABE);
    push_wr(20'h00000, 16'hCAFE);
    do_op("i32_wrap", 32'hCAFE_BABE, 1'b1, 5'b00011, 20'hFFFFE, 6, 4'b0000, 1'b0);

    // Ack never arrives: bus error after TO wait cycles, word 1 never attempted
    ack_delay  = -1;
    req_cycles = 0;
    push_wr(20'hFFFFE, 16'h1111);
    do_op("i32_timeout", 32'h2222_1111, 1'b1, 5'b00011, 20'hFFFFE, 7, 4'b0001, 1'b0);
    check("timeout:req_cycles", 32'(req_cycles), 32'(TO));

    // Reset during WRITE abandons the transfer
    push_wr(20'h05000, 16'h3333);
    int_in    = 32'h4444_3333;
    int_size  = 1'b1;
    {in_invalid, in_overflow, in_inexact, im_mask, pm_mask} = 5'b00111;
    base_addr = 20'h05000;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst:req_before", 32'(mem_wr_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst:req", 32'(mem_wr_req), 32'd0);
    check("midrst:busy_done", 32'({busy, done}), 32'd0);
    check("midrst:addr_data", 32'({mem_addr, mem_wdata} != '0), 32'd0);
    check("midrst:flags", 32'({exc_invalid, exc_precision, fault, bus_error}), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst:no_done", 32'(done), 32'd0);
    end
    exp_q.delete();
    reset_n   = 1'b1;
    ack_delay = 0;
    @(posedge clk); #1;
    check("postrst:no_done", 32'(done), 32'd0);

    push_wr(20'h06000, 16'h0042);
    do_op("postrst_i16", 32'h0000_0042, 1'b0, 5'b00011, 20'h06000, 4, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
